imem_responder: RTL
===================

Name: imem_responder

Overview:
Instruction-memory responder that serves the fetch stage's 16-bit instruction requests with a fixed, programmable access latency.
- Drives a stall signal that the fetch stage uses as its freeze input, so the PC holds until the instruction word returns.
- Supports redirect flushes from branch resolution.
- Has a loader write port so benches and boot logic can preload program memory.

Parameters:
ADDR_W, 10, word-address width; array holds 2^ADDR_W 16-bit words
LATENCY, 3, cycles from request accept edge to instr_valid (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  1  fetch request; addr sampled at the accept edge
addr  in  16  byte address; word index = addr[ADDR_W:1]; bits above are ignored (aliasing)
flush  in  1  cancels any in-flight request (branch redirect)
instr  out  16  returned instruction word
instr_valid  out  1  one-cycle pulse, instr is valid
fault  out  1  with instr_valid: returned request was misaligned
stall  out  1  freeze request to the fetch stage
busy  out  1  request in flight (state != IDLE)
ld_en  in  1  loader write strobe
ld_addr  in  16  loader byte address (same mapping as addr)
ld_data  in  16  loader write data
ld_err  out  1  one-cycle pulse: loader write rejected

Behaviour:
- Reset (rst=0, async): state=IDLE, instr=16'h0000, instr_valid=0, fault=0, ld_err=0, counter=0. Array contents are not reset.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting down the access latency.
  - DONE: response cycle.
- Accept: an edge in IDLE or DONE with req=1 latches addr and loads the counter with LATENCY-1.
  - If LATENCY-1 is 0, next state is DONE; otherwise WAIT.
- WAIT: the counter decrements each edge. On the edge where the counter equals 1, the next state is DONE.
  - Result: a request accepted at edge k gives instr_valid=1 in the cycle after edge k+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- Array read timing: the array is read on the edge entering DONE.
  - instr and instr_valid are registered outputs.
  - instr_valid is high only in DONE.
  - instr holds its last value otherwise.
- Back-to-back requests: in DONE, req=1 accepts a new request; otherwise the next state is IDLE.
- stall is combinational: stall = (req & ~flush & state!=WAIT & ~done_accepting_none) | (state==WAIT).
  - Simplified rule: stall=1 from the accept cycle until the cycle before instr_valid.
  - stall=0 in the DONE cycle and in IDLE with req=0.
- Misaligned request (addr[0]=1): the request is accepted and timed normally. In DONE, instr=16'h0000 (NOP) and fault=1.
- flush=1 at any edge:
  - Any in-flight request is discarded; no instr_valid is produced for it.
  - If req=1 in the same cycle, the new addr is accepted (redirect wins).
  - Otherwise the next state is IDLE.
  - Flush in the DONE cycle does not suppress that cycle's already-registered pulse.
- Loader writes:
  - ld_en=1 with busy=0: synchronous write of mem[ld_addr[ADDR_W:1]] ← ld_data at the edge.
  - ld_en=1 with busy=1: the write is dropped and ld_err pulses for one cycle.
  - ld_en and req in the same IDLE cycle: the write completes, then the request reads the new data.
  - ld_addr[0] is ignored.

Optional Feature:
IMEM_HIT_BUF_EN
- With the macro defined: a single-entry buffer holds the word index and data of the last aligned response.
  - A request whose word index matches the buffer goes straight to DONE, so instr_valid arrives one cycle after accept, regardless of LATENCY.
  - A loader write to the buffered index, or reset, invalidates the buffer.
  - flush does not invalidate it.
- Without the macro: every request takes LATENCY cycles and no buffer storage exists.

Decomposition:
- Package imem_pkg holds:
  - the state enum {IDLE, WAIT, DONE};
  - the constant IMEM_NOP = 16'h0000;
  - the counter width constant LAT_W = 4.
- Sub-module imem_array: a 2^ADDR_W x 16 array with a synchronous write port and a registered read port. The responder FSM, counter and hit buffer live in the top module.

Test Plan:
- Preload mem[0x10]=16'hA5A5 via the loader; with LATENCY=3, req at addr 16'h0020 → stall high for 3 cycles, instr_valid at edge+3, instr=A5A5, fault=0.
- Hold req high with addr 0x0020, 0x0022, 0x0024 accepted in each DONE cycle → a valid pulse every LATENCY cycles with the correct words and no gaps.
- req addr 16'h0021 → instr=16'h0000, fault=1, same latency.
- Accept 0x0020, then assert flush with req at 0x0040 one cycle later → no response for 0x0020; mem[0x20] returned LATENCY cycles after the flush edge.
- ld_en while busy=1 → ld_err pulses and the array is unchanged (read-back confirms the old value). Assert rst mid-WAIT → instr_valid never fires and all outputs are 0.
- IMEM_HIT_BUF_EN: repeat req 0x0020 → valid 1 cycle after accept; a loader write to 0x0020 followed by req → full LATENCY and the new data.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
package imem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [15:0] IMEM_NOP = 16'h0000;
    localparam int LAT_W = 4;
endpackage

// File: rtl/imem_array.sv
// imem_array: 2^ADDR_W x 16 program memory, synchronous write, registered write-first read.
module imem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);
    logic [15:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with flush and loader port.
// Optional single-entry hit buffer enabled by defining IMEM_HIT_BUF_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        flush,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        fault,
    output logic        stall,
    output logic        busy,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_err
);
    localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

    state_t           state, nxt;
    logic [LAT_W-1:0] cnt, cnt_nxt;
    logic [ADDR_W:0]  addr_q, cur;
    logic [15:0]      rdata;
    logic             accept, wr, re, hit, nop_q;
    logic             unused;

    assign unused = ^{addr[15:ADDR_W+1], ld_addr[15:ADDR_W+1], ld_addr[0]};
    assign busy   = state != IDLE;
    assign wr     = ld_en & ~busy;
    assign accept = req & (state != WAIT | flush);
    assign cur    = accept ? addr[ADDR_W:0] : addr_q;
    // The read register only ever loads on an aligned response, so it doubles as hit-buffer data.
    assign re     = nxt == DONE & ~cur[0] & ~(accept & hit);

`ifdef IMEM_HIT_BUF_EN
    logic              buf_vld;
    logic [ADDR_W-1:0] buf_idx;

    assign hit = buf_vld & buf_idx == addr[ADDR_W:1] & ~(wr & ld_addr[ADDR_W:1] == buf_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld <= 1'b0;
            buf_idx <= '0;
        end else if (re) begin
            buf_vld <= 1'b1;
            buf_idx <= cur[ADDR_W:1];
        end else if (wr && ld_addr[ADDR_W:1] == buf_idx) begin
            buf_vld <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        if (accept) begin
            nxt     = (hit || LAT_M1 == '0) ? DONE : WAIT;
            cnt_nxt = LAT_M1;
        end else if (flush || state == DONE) begin
            nxt = IDLE;
        end else if (state == WAIT) begin
            nxt     = cnt == LAT_W'(1) ? DONE : WAIT;
            cnt_nxt = cnt - 1'b1;
        end
    end

    // nop_q resets high so instr reads as NOP until the first aligned response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            nop_q  <= 1'b1;
            ld_err <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_nxt;
            ld_err <= ld_en & busy;
            if (accept) addr_q <= addr[ADDR_W:0];
            if (nxt == DONE) nop_q <= cur[0];
        end
    end

    imem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (wr),
        .waddr (ld_addr[ADDR_W:1]),
        .wdata (ld_data),
        .re    (re),
        .raddr (cur[ADDR_W:1]),
        .rdata (rdata)
    );

    assign instr       = nop_q ? IMEM_NOP : rdata;
    assign instr_valid = state == DONE;
    assign fault       = instr_valid & nop_q;
    assign stall       = state == WAIT | (state == IDLE & req & ~flush);
endmodule
